// File: rtl/alu_operand_entry.sv
// alu_operand_entry: debounced switch/button entry of {a,b,op} for the ALU, offered via valid/ready.
// ALU_ENTRY_SYNC2_EN selects a two-flop btn synchronizer instead of a single register.
module alu_operand_entry #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic [2:0] op_sw,
    input  logic       btn,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic       valid,
    input  logic       ready,
    output logic [1:0] stage,
    output logic [7:0] issued
);
    typedef enum logic [1:0] {GET_A, GET_B, GET_OP, ISSUE} state_t;
    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       issued_q, issued_d;
    logic             sync_q, sync_d;
    logic             deb_q, deb_d, deb_prev_q, deb_prev_d, press_q, press_d;
    logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             deb_hit;
`ifdef ALU_ENTRY_SYNC2_EN
    logic meta_q, meta_d;
    assign meta_d = btn;
    always_ff @(posedge clk)
        if (rst) meta_q <= 1'b0;
        else     meta_q <= meta_d;
    assign sync_d = meta_q;
`else
    assign sync_d = btn;
`endif
    always_comb begin
        cnt_inc    = cnt_q + 1'b1;
        deb_hit    = (sync_q != deb_q) && (cnt_inc == DEB_W'(DEB_CYCLES));
        deb_d      = deb_hit ? ~deb_q : deb_q;
        cnt_d      = (sync_q == deb_q || deb_hit) ? '0 : cnt_inc;
        deb_prev_d = deb_q;
        press_d    = deb_q & ~deb_prev_q;
    end
    // Presses outside the capture states fall through untouched, so nothing queues during ISSUE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        issued_d = issued_q;
        case (state_q)
            GET_A:   if (press_q) begin a_d = sw; state_d = GET_B; end
            GET_B:   if (press_q) begin b_d = sw; state_d = GET_OP; end
            GET_OP:  if (press_q) begin op_d = op_sw; state_d = ISSUE; end
            ISSUE:   if (ready) begin issued_d = issued_q + 8'd1; state_d = GET_A; end
            default: state_d = GET_A;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            press_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= GET_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            issued_q   <= '0;
        end else begin
            sync_q     <= sync_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            issued_q   <= issued_d;
        end
    end
    assign a      = a_q;
    assign b      = b_q;
    assign op     = op_q;
    assign valid  = (state_q == ISSUE);
    assign stage  = state_q;
    assign issued = issued_q;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: directed checks of entry, debounce, latency, ISSUE hold and counter wrap with DEB_CYCLES=4.
module tb_alu_operand_entry;
    logic       clk = 1'b0;
    logic       rst, btn, ready, valid;
    logic [3:0] sw, a, b;
    logic [2:0] op_sw, op;
    logic [1:0] stage;
    logic [7:0] issued;
    int checks = 0, failures = 0, vcnt = 0, n;
    alu_operand_entry #(.DEB_CYCLES(4), .DEB_W(20)) dut (
        .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw), .btn(btn),
        .a(a), .b(b), .op(op), .valid(valid), .ready(ready),
        .stage(stage), .issued(issued)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic press(input int hold);
        btn = 1'b1;
        repeat (hold) begin @(negedge clk); if (valid) vcnt++; end
        btn = 1'b0;
        repeat (12) begin @(negedge clk); if (valid) vcnt++; end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1; btn = 1'b0; ready = 1'b0; sw = 4'h0; op_sw = 3'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_stage", 8'(stage), 8'd0);
        check("rst_a", 8'(a), 8'h0);
        check("rst_b", 8'(b), 8'h0);
        check("rst_op", 8'(op), 8'h0);
        check("rst_valid", 8'(valid), 8'd0);
        check("rst_issued", issued, 8'd0);
        sw = 4'h5; press(4);
        check("a_first", 8'(a), 8'h5);
        check("stage_after_a", 8'(stage), 8'd1);
        do_reset();
        check("midrst_stage", 8'(stage), 8'd0);
        check("midrst_a", 8'(a), 8'h0);
        check("midrst_valid", 8'(valid), 8'd0);
        check("midrst_issued", issued, 8'd0);
        sw = 4'h3; press(4);
        check("a_recapture", 8'(a), 8'h3);
        check("stage_recapture", 8'(stage), 8'd1);
        sw = 4'h2; press(3);
        check("glitch_stage", 8'(stage), 8'd1);
        check("glitch_b", 8'(b), 8'h0);
        sw = 4'hA; n = 0; btn = 1'b1;
        while (stage == 2'd1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
`ifdef ALU_ENTRY_SYNC2_EN
        check("latency", 8'(n), 8'd8);
`else
        check("latency", 8'(n), 8'd7);
`endif
        check("b_capture", 8'(b), 8'hA);
        check("stage_after_b", 8'(stage), 8'd2);
        op_sw = 3'b001; press(100);
        check("long_stage", 8'(stage), 8'd3);
        check("cmd_valid", 8'(valid), 8'd1);
        check("cmd_a", 8'(a), 8'h3);
        check("cmd_b", 8'(b), 8'hA);
        check("cmd_op", 8'(op), 8'h1);
        sw = 4'hF; op_sw = 3'h7;
        repeat (3) press(5);
        check("hold_valid", 8'(valid), 8'd1);
        check("hold_a", 8'(a), 8'h3);
        check("hold_b", 8'(b), 8'hA);
        check("hold_op", 8'(op), 8'h1);
        check("hold_stage", 8'(stage), 8'd3);
        ready = 1'b1; @(negedge clk); ready = 1'b0;
        check("acc_valid", 8'(valid), 8'd0);
        check("acc_issued", issued, 8'd1);
        check("acc_stage", 8'(stage), 8'd0);
        check("acc_keep_op", 8'(op), 8'h1);
        sw = 4'h7; press(4);
        check("post_a", 8'(a), 8'h7);
        check("post_stage", 8'(stage), 8'd1);
        check("post_b", 8'(b), 8'hA);
        do_reset();
        ready = 1'b1; vcnt = 0;
        for (int i = 0; i < 256; i++) begin
            sw = 4'(i); op_sw = 3'(i);
            repeat (3) press(4);
            if (i == 254) check("issued_255", issued, 8'd255);
        end
        check("wrap_issued", issued, 8'd0);
        check("wrap_valid_cycles", 8'(vcnt >> 1), 8'd128);
        check("wrap_valid_lsb", 8'(vcnt & 1), 8'd0);
        check("wrap_stage", 8'(stage), 8'd0);
        check("wrap_last_a", 8'(a), 8'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Front end that produces the operands and opcode consumed by the 4-bit ALU/7-segment result path.
- Collects A, B and op from board switches, one field per debounced press of the enter button.
- Presents the collected command to the ALU side through a valid/ready handshake.
- Sits between the NVBoard switch/button inputs and the ALU; drives stage LEDs and an issued-command counter.

Parameters:
- DEB_CYCLES, 16: consecutive cycles a raw button level must differ from the debounced level before the debounced level flips. Legal range is 1 to 2^DEB_W-1.
- DEB_W, 20: width of the debounce counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  4  data switches; value for A or B.
- op_sw  input  3  opcode switches.
- btn  input  1  raw enter button, asynchronous to clk, active high.
- a  output  4  captured operand A.
- b  output  4  captured operand B.
- op  output  3  captured opcode.
- valid  output  1  command {a,b,op} is complete and offered.
- ready  input  1  consumer accepts the command when valid&&ready.
- stage  output  2  0=GET_A, 1=GET_B, 2=GET_OP, 3=ISSUE; for LEDs.
- issued  output  8  count of accepted commands; wraps 255->0.

Behaviour:
- Reset (rst high at a clk edge): state GET_A, stage=0, a=b=0, op=0, valid=0, issued=0. Synchronizer flops, debounced level and debounce counter all clear to 0. Reset overrides everything, including mid-entry and mid-handshake; a partially entered command is discarded.
- Input sampling: btn passes through the synchronizer (see Optional Feature) to give btn_s.
- Debounce:
  - If btn_s equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it would reach DEB_CYCLES, the debounced level flips and the counter clears in the same edge.
  - With DEB_CYCLES=N, a level change held for N consecutive btn_s cycles flips the debounced level. A shorter glitch flips nothing.
- Press event: a registered one-cycle pulse, asserted in the cycle after the debounced level goes 0->1. Releases (1->0) generate no event.
- FSM, evaluated on the press pulse unless noted:
  - GET_A + press: a<=sw, go to GET_B.
  - GET_B + press: b<=sw, go to GET_OP.
  - GET_OP + press: op<=op_sw, go to ISSUE. valid is 1 in the cycle after the capturing edge.
  - ISSUE: valid=1; a, b and op are held stable; presses are ignored and dropped, not queued.
  - ISSUE + valid&&ready at an edge: go to GET_A, valid=0 from the next cycle, issued<=issued+1 (mod 256).
- Captured a, b and op keep their values until overwritten, including after acceptance. The ALU display therefore keeps the last result.
- Switch values are sampled only on the capturing edge; switch changes at any other time have no effect.
- ready is ignored outside ISSUE. ready may be held high permanently, giving a 1-cycle ISSUE.
- valid never drops without acceptance, except on reset.
- stage always equals the state encoding, registered (no combinational path from btn).

Optional Feature:
- Macro: ALU_ENTRY_SYNC2_EN.
- Defined: btn goes through a two-flop synchronizer, so btn_s lags btn by 2 cycles.
- Undefined: a single register, so btn_s lags btn by 1 cycle.
- All other behaviour is identical. Total press-to-pulse latency differs by exactly one cycle.

Test Plan:
- Reset mid-entry, DEB_CYCLES=4: enter A=4'h5, then assert rst for 1 cycle -> stage=0, a=0, valid=0, issued=0. The next press captures A again.
- Full command: sw=4'h3 press, sw=4'hA press, op_sw=3'b001 press, ready=0 -> valid=1 held with a=3, b=A, op=1, stage=3. Assert ready for 1 cycle -> valid=0 next cycle, issued=1, stage=0.
- Debounce with DEB_CYCLES=4: btn pulse of 3 cycles -> no press pulse, stage unchanged. A 4-cycle press -> exactly one pulse. A press held 100 cycles -> exactly one pulse.
- Press latency: time from btn rise to press pulse is 1+4+1 cycles with ALU_ENTRY_SYNC2_EN undefined, and one more cycle with it defined. Verify both builds.
- Presses during ISSUE with ready=0: 3 presses -> a/b/op unchanged, still valid=1. After acceptance, the next press captures A rather than anything queued.
- Counter wrap: 256 commands issued with ready tied to 1 -> issued returns to 0; each ISSUE lasts exactly 1 cycle.
